// File: rtl/amo_sequencer.sv
// Atomic memory operation sequencer: read-modify-write of one word through an
// external combinational ALU, with posted write and old-value response.
module amo_sequencer #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [15:0]       req_op,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       alu_in1,
  output logic [31:0]       alu_in2,
  output logic [15:0]       alu_op,
  input  logic [63:0]       alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_err
);

  typedef enum logic [2:0] {StIdle, StRdReq, StRdWait, StCalc, StWrReq, StResp} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [15:0]       op_q;
  logic [31:0]       old_q;
  logic [31:0]       new_q;
  logic              req_ready_q;
  logic              mem_req_valid_q;
  logic              mem_we_q;
  logic [15:0]       alu_op_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [31:0]       rsp_data_q;
  logic              req_ok;
  logic              unused_alu_hi;

  function automatic logic op_legal(input logic [15:0] op);
    logic legal;
    case (op)
      16'h0001, 16'h0004, 16'h0008, 16'h0010,
      16'h2000, 16'h4000, 16'h8000: legal = 1'b1;
      default:                      legal = 1'b0;
    endcase
    return legal;
  endfunction

  assign req_ok        = op_legal(req_op) && (req_addr[1:0] == 2'b00);
  assign unused_alu_hi = ^alu_result[63:32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      data_q          <= '0;
      op_q            <= '0;
      old_q           <= '0;
      new_q           <= '0;
      req_ready_q     <= 1'b1;
      mem_req_valid_q <= 1'b0;
      mem_we_q        <= 1'b0;
      alu_op_q        <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_err_q       <= 1'b0;
      rsp_data_q      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid && req_ready_q) begin
            addr_q      <= req_addr;
            data_q      <= req_data;
            op_q        <= req_op;
            req_ready_q <= 1'b0;
            if (req_ok) begin
              state_q         <= StRdReq;
              mem_req_valid_q <= 1'b1;
              mem_we_q        <= 1'b0;
            end else begin
              // Rejected requests never touch memory.
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= '0;
            end
          end
        end
        StRdReq: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= StRdWait;
          end
        end
        StRdWait: begin
          if (mem_rsp_valid) begin
            old_q    <= mem_rdata;
            alu_op_q <= op_q;
            state_q  <= StCalc;
          end
        end
        StCalc: begin
          new_q           <= alu_result[31:0];
          alu_op_q        <= '0;
          mem_req_valid_q <= 1'b1;
          mem_we_q        <= 1'b1;
          state_q         <= StWrReq;
        end
        StWrReq: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            mem_we_q        <= 1'b0;
            rsp_valid_q     <= 1'b1;
            rsp_err_q       <= 1'b0;
            rsp_data_q      <= old_q;
            state_q         <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            req_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q         <= StIdle;
          req_ready_q     <= 1'b1;
          mem_req_valid_q <= 1'b0;
          mem_we_q        <= 1'b0;
          alu_op_q        <= '0;
          rsp_valid_q     <= 1'b0;
          rsp_err_q       <= 1'b0;
          rsp_data_q      <= '0;
        end
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = new_q;
  assign alu_in1       = old_q;
  assign alu_in2       = data_q;
  assign alu_op        = alu_op_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_amo_sequencer.sv
// Bench for amo_sequencer: transaction-level model with a per-cycle checker,
// a behavioural memory and ALU, and directed requests with literal expectations.
module tb_amo_sequencer;

  localparam int unsigned ADDR_W = 32;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic [15:0]       req_op;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_rsp_valid;
  logic [31:0]       mem_rdata;
  logic [31:0]       alu_in1;
  logic [31:0]       alu_in2;
  logic [15:0]       alu_op;
  logic [63:0]       alu_result;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic              rsp_err;

  amo_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_data(req_data), .req_op(req_op),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural ALU: signed MAX/MIN, junk upper half must be ignored.
  function automatic logic [31:0] alu_model(input logic [15:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      16'h0001: return a + b;
      16'h0004: return a ^ b;
      16'h0008: return a | b;
      16'h0010: return a & b;
      16'h2000: return b;
      16'h4000: return ($signed(a) > $signed(b)) ? a : b;
      16'h8000: return ($signed(a) < $signed(b)) ? a : b;
      default:  return 32'h0;
    endcase
  endfunction

  always_comb alu_result = {32'hA5A5_5A5A, alu_model(alu_op, alu_in1, alu_in2)};

  function automatic logic is_legal(input logic [15:0] op, input logic [31:0] addr);
    return (op == 16'h0001 || op == 16'h0004 || op == 16'h0008 || op == 16'h0010 ||
            op == 16'h2000 || op == 16'h4000 || op == 16'h8000) && (addr[1:0] == 2'b00);
  endfunction

  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Environment controls and observations
  int          stall_rd = 0, stall_wr = 0, stall_rsp = 0;
  logic        no_auto = 1'b0;
  logic        pend_valid = 1'b0;
  logic [31:0] pend_data = 32'h0;
  int          cyc = 0;
  int          acc_cnt = 0, rd_cnt = 0, wr_cnt = 0, rsp_cnt = 0, memv_since_rst = 0;
  int          last_acc_cyc = 0, last_wr_cyc = 0, last_rsp_cyc = 0;
  logic [31:0] last_waddr = 0, last_wdata = 0, last_rsp_data = 0;
  logic        last_rsp_err = 0, ready_after = 0;
  int          last_alu_cnt = 0;

  // Transaction model: at most one outstanding request.
  logic        active = 0, t_err = 0, rd_done = 0, wr_done = 0;
  logic [31:0] t_addr = 0, t_data = 0, t_old = 0, t_new = 0;
  logic [15:0] t_op = 0;
  int          alu_cnt = 0;

  logic        prev_mstall = 0, prev_rstall = 0, prev_rsp_hs = 0;
  logic        s_mv = 0, s_we = 0, s_rv = 0, s_re = 0;
  logic [31:0] s_ma = 0, s_wd = 0, s_rd = 0;

  always @(posedge clk) begin
    #1;
    mem_req_ready = !(mem_req_valid && (mem_we ? (stall_wr != 0) : (stall_rd != 0)));
    rsp_ready     = !(rsp_valid && (stall_rsp != 0));
    if (!no_auto) begin
      mem_rsp_valid = pend_valid;
      mem_rdata     = pend_valid ? pend_data : 32'h0;
      pend_valid    = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      active = 0; pend_valid = 0; prev_mstall = 0; prev_rstall = 0; prev_rsp_hs = 0;
      memv_since_rst = 0;
    end else begin
      cyc++;
      chk("no_x", {31'h0, $isunknown({req_ready, mem_req_valid, mem_we, mem_addr, mem_wdata,
                                      alu_in1, alu_in2, alu_op, rsp_valid, rsp_data,
                                      rsp_err})}, 32'h0);
      chk("req_ready_idle", {31'h0, req_ready}, {31'h0, !active});
      if (prev_mstall) begin
        chk("mreq_stable_valid", {31'h0, mem_req_valid}, {31'h0, s_mv});
        chk("mreq_stable_we", {31'h0, mem_we}, {31'h0, s_we});
        chk("mreq_stable_addr", mem_addr, s_ma);
        if (s_we) chk("mreq_stable_wdata", mem_wdata, s_wd);
      end
      if (prev_rstall) begin
        chk("rsp_stable_valid", {31'h0, rsp_valid}, {31'h0, s_rv});
        chk("rsp_stable_data", rsp_data, s_rd);
        chk("rsp_stable_err", {31'h0, rsp_err}, {31'h0, s_re});
      end
      if (ready_after === 1'bx) ready_after = 0;
      if (prev_rsp_hs) ready_after = req_ready;
      if (mem_req_valid) begin
        memv_since_rst++;
        chk("mreq_allowed", {31'h0, active && !t_err && !wr_done}, 32'h1);
        chk("mreq_phase_we", {31'h0, mem_we}, {31'h0, rd_done});
      end
      if (rsp_valid) chk("rsp_allowed", {31'h0, active}, 32'h1);
      if (alu_op != 16'h0) begin
        alu_cnt++;
        chk("alu_op_window", {31'h0, active && rd_done && !wr_done}, 32'h1);
        chk("alu_op_value", {16'h0, alu_op}, {16'h0, t_op});
        chk("alu_in1", alu_in1, t_old);
        chk("alu_in2", alu_in2, t_data);
      end
      if (mem_req_valid && mem_req_ready) begin
        if (!mem_we) begin
          rd_cnt++;
          chk("rd_once", {31'h0, rd_done}, 32'h0);
          chk("rd_addr", mem_addr, t_addr);
          rd_done    = 1;
          pend_valid = 1'b1;
          pend_data  = rd_mem(mem_addr);
        end else begin
          wr_cnt++;
          chk("wr_once", {31'h0, wr_done}, 32'h0);
          chk("wr_addr", mem_addr, t_addr);
          chk("wr_data", mem_wdata, t_new);
          wr_done = 1;
          mem[mem_addr] = mem_wdata;
          last_wr_cyc = cyc; last_waddr = mem_addr; last_wdata = mem_wdata;
        end
      end
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        chk("rsp_err", {31'h0, rsp_err}, {31'h0, t_err});
        chk("rsp_data", rsp_data, t_err ? 32'h0 : t_old);
        chk("rsp_after_write", {31'h0, wr_done}, {31'h0, !t_err});
        chk("alu_cycles", alu_cnt, t_err ? 0 : 1);
        last_rsp_cyc = cyc; last_rsp_data = rsp_data; last_rsp_err = rsp_err;
        last_alu_cnt = alu_cnt;
        active = 0;
      end
      prev_rsp_hs = rsp_valid && rsp_ready;
      if (req_valid && req_ready) begin
        acc_cnt++;
        last_acc_cyc = cyc;
        active = 1; rd_done = 0; wr_done = 0; alu_cnt = 0;
        t_addr = req_addr; t_data = req_data; t_op = req_op;
        t_err  = !is_legal(req_op, req_addr);
        t_old  = rd_mem(req_addr);
        t_new  = alu_model(req_op, t_old, req_data);
      end
      prev_mstall = mem_req_valid && !mem_req_ready;
      s_mv = mem_req_valid; s_we = mem_we; s_ma = mem_addr; s_wd = mem_wdata;
      prev_rstall = rsp_valid && !rsp_ready;
      s_rv = rsp_valid; s_rd = rsp_data; s_re = rsp_err;
      if (mem_req_valid && !mem_req_ready) begin
        if (mem_we) stall_wr--; else stall_rd--;
      end
      if (rsp_valid && !rsp_ready) stall_rsp--;
    end
  end

  task automatic start_req(input logic [31:0] a, input logic [31:0] d, input logic [15:0] op);
    int n0;
    bit ok;
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = a; req_data = d; req_op = op;
    n0 = acc_cnt;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (acc_cnt != n0) begin ok = 1; break; end
    end
    req_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: request %h not accepted within 50 cycles", a);
    end
  endtask

  task automatic wait_rsp();
    int n0;
    bit ok;
    n0 = rsp_cnt;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (rsp_cnt != n0) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: no response within 100 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [15:0] op);
    start_req(a, d, op);
    wait_rsp();
  endtask

  int memv0, wr0;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0; req_op = '0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rdata = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_mem_req_valid", {31'h0, mem_req_valid}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_alu_op", {16'h0, alu_op}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);

    // ADD at zero wait: write at cycle 4, response at cycle 5, ready at 6
    mem[32'h100] = 32'd5;
    do_req(32'h100, 32'd3, 16'h0001);
    chk("add_wr_lat", last_wr_cyc - last_acc_cyc, 4);
    chk("add_wr_addr", last_waddr, 32'h100);
    chk("add_wr_data", last_wdata, 32'd8);
    chk("add_rsp_lat", last_rsp_cyc - last_acc_cyc, 5);
    chk("add_rsp_data", last_rsp_data, 32'd5);
    chk("add_rsp_err", {31'h0, last_rsp_err}, 32'h0);
    chk("add_ready_after", {31'h0, ready_after}, 32'h1);

    // SWAP with three stall cycles on both memory requests
    mem[32'h40] = 32'hDEAD_BEEF;
    stall_rd = 3; stall_wr = 3;
    do_req(32'h40, 32'h1, 16'h2000);
    chk("swap_wr_data", last_wdata, 32'h1);
    chk("swap_rsp_data", last_rsp_data, 32'hDEAD_BEEF);
    chk("swap_rsp_lat", last_rsp_cyc - last_acc_cyc, 11);

    // Illegal opcodes and misaligned address: error, no memory traffic
    memv0 = memv_since_rst;
    do_req(32'h80, 32'h7, 16'h0002);
    chk("illop_err", {31'h0, last_rsp_err}, 32'h1);
    chk("illop_data", last_rsp_data, 32'h0);
    chk("illop_lat", last_rsp_cyc - last_acc_cyc, 1);
    do_req(32'h102, 32'h7, 16'h0001);
    chk("misalign_err", {31'h0, last_rsp_err}, 32'h1);
    chk("misalign_data", last_rsp_data, 32'h0);
    do_req(32'h80, 32'h7, 16'h0005);
    chk("twohot_err", {31'h0, last_rsp_err}, 32'h1);
    chk("illegal_no_mem", memv_since_rst - memv0, 0);

    // XOR with response back-pressure for four cycles
    mem[32'h10] = 32'h0000_F0F0;
    stall_rsp = 4;
    do_req(32'h10, 32'h0000_0FF0, 16'h0004);
    chk("xor_wr_data", last_wdata, 32'h0000_FF00);
    chk("xor_rsp_data", last_rsp_data, 32'h0000_F0F0);
    chk("xor_rsp_lat", last_rsp_cyc - last_acc_cyc, 9);
    chk("xor_ready_after", {31'h0, ready_after}, 32'h1);

    // Reset while waiting for read data; the late data must be ignored
    mem[32'h200] = 32'h11;
    no_auto = 1'b1;
    wr0 = wr_cnt;
    start_req(32'h200, 32'h1, 16'h0001);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1; mem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0; mem_rdata = 32'h0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("rstmid_no_write", wr_cnt - wr0, 0);
    chk("rstmid_no_mreq", memv_since_rst, 0);
    chk("rstmid_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rstmid_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rstmid_rsp_data", rsp_data, 32'h0);
    chk("rstmid_alu_op", {16'h0, alu_op}, 32'h0);
    chk("rstmid_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rstmid_mem_kept", mem[32'h200], 32'h11);
    no_auto = 1'b0;

    // MIN / MAX: result is whatever the ALU returns
    mem[32'h20] = 32'd7;
    do_req(32'h20, 32'd2, 16'h8000);
    chk("min_wr_data", last_wdata, 32'd2);
    chk("min_rsp_data", last_rsp_data, 32'd7);
    chk("min_alu_cycles", last_alu_cnt, 1);
    mem[32'h30] = 32'hFFFF_FFFF;
    do_req(32'h30, 32'd1, 16'h4000);
    chk("max_wr_data", last_wdata, 32'd1);
    chk("max_rsp_data", last_rsp_data, 32'hFFFF_FFFF);

    // OR, AND, then re-check the first ADD target still accumulates
    mem[32'h50] = 32'hF000_000F;
    do_req(32'h50, 32'h0F00_00F0, 16'h0008);
    chk("or_wr_data", last_wdata, 32'hFF00_00FF);
    do_req(32'h50, 32'h0FF0_0FF0, 16'h0010);
    chk("and_wr_data", last_wdata, 32'h0F00_00F0);
    chk("and_rsp_data", last_rsp_data, 32'hFF00_00FF);
    do_req(32'h100, 32'd10, 16'h0001);
    chk("add2_rsp_data", last_rsp_data, 32'd8);
    chk("add2_wr_data", last_wdata, 32'd18);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/amo_sequencer.md
AMO_SEQUENCER -- requirements
Module: amo_sequencer

Interface
REQ-001 Parameter: ADDR_W, default 32, width of the memory address paths.
REQ-002 Ports, clock and reset first: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  input  1  AMO request present; req_ready  output  1  sequencer can accept.
REQ-005 req_addr  input  ADDR_W  word address; req_data  input  32  rs2 operand; req_op  input  16  one-hot opcode.
REQ-006 mem_req_valid  output  1; mem_req_ready  input  1; mem_we  output  1; mem_addr  output  ADDR_W; mem_wdata  output  32.
REQ-007 mem_rsp_valid  input  1  read data return; mem_rdata  input  32.
REQ-008 alu_in1  output  32; alu_in2  output  32; alu_op  output  16; alu_result  input  64  from the combinational ALU.
REQ-009 rsp_valid  output  1; rsp_ready  input  1; rsp_data  output  32  old memory value; rsp_err  output  1.

Function
REQ-010 Legal req_op values SHALL be exactly 1 (ADD), 4 (XOR), 8 (OR), 16 (AND), 8192 (SWAP), 16384 (MAX), 32768 (MIN); any other value is illegal.
REQ-011 States SHALL be IDLE, RD_REQ, RD_WAIT, CALC, WR_REQ, RESP.
REQ-012 req_ready SHALL be 1 only in IDLE; handshake = req_valid && req_ready latches addr, data, op.
REQ-013 IDLE->RESP with rsp_err=1, rsp_data=0, no memory access if op illegal or req_addr[1:0]!=0; otherwise IDLE->RD_REQ.
REQ-014 RD_REQ: mem_req_valid=1, mem_we=0, mem_addr=latched addr; hold stable until mem_req_ready; then ->RD_WAIT.
REQ-015 RD_WAIT: on mem_rsp_valid latch mem_rdata as old value, ->CALC; mem_rsp_valid in any other state SHALL be ignored.
REQ-016 CALC (exactly one cycle): alu_in1=old value, alu_in2=latched data, alu_op=latched op; latch alu_result[31:0] as new value, ->WR_REQ.
REQ-017 alu_op SHALL be 0 outside CALC; alu_in1/alu_in2 don't-care outside CALC but SHALL not be X.
REQ-018 WR_REQ: mem_req_valid=1, mem_we=1, mem_addr=latched addr, mem_wdata=new value; held until mem_req_ready; write is posted (no response); then ->RESP.
REQ-019 RESP: rsp_valid=1, rsp_data=old value, rsp_err=0; outputs stable until rsp_ready; then ->IDLE.
REQ-020 mem_req_valid SHALL never be 1 outside RD_REQ/WR_REQ; at most one read and one write per request.
REQ-021 Minimum latency with ready/rsp asserted immediately: accept (cycle 0), RD_REQ 1, RD_WAIT 2, CALC 3, WR_REQ 4, RESP 5; req_ready again at cycle 6.
REQ-022 A new request SHALL NOT be accepted in the cycle the response handshakes; req_ready rises the following cycle.
REQ-023 Sequencer SHALL not interpret MAX/MIN signedness; result is whatever alu_result[31:0] returns.

Reset
REQ-024 rst_n low SHALL immediately force IDLE; req_ready=1 once released, mem_req_valid=0, mem_we=0, rsp_valid=0, rsp_err=0, rsp_data=0, alu_op=0, latched registers=0.
REQ-025 Reset mid-operation SHALL abandon the transaction with no further memory request; a pending write not yet handshaken SHALL NOT be issued.

Verification
REQ-026 ADD: mem[0x100]=5, req addr 0x100 data 3 op 1, zero-wait memory -> write 8 to 0x100 at cycle 4, rsp_data=5 at cycle 5, rsp_err=0.
REQ-027 SWAP with mem_req_ready low 3 cycles in each of RD_REQ and WR_REQ: mem[0x40]=0xDEADBEEF, data 0x1 -> addr/we/wdata stable while stalled, write 0x1, rsp_data=0xDEADBEEF.
REQ-028 Illegal op 2 and misaligned addr 0x102 (op 1) -> rsp_err=1, rsp_data=0, mem_req_valid never asserted.
REQ-029 rsp_ready held low 4 cycles -> rsp_valid/rsp_data stable, req_ready=0 throughout, req_ready=1 cycle after handshake.
REQ-030 rst_n pulsed low in RD_WAIT, then late mem_rsp_valid -> ignored, no write issued, outputs at reset values.
REQ-031 MIN with mem=7, data=2, ALU model returning smaller -> write 2, rsp_data=7; alu_op=32768 only in CALC cycle.
